// File: rtl/flit_depacketizer_if.sv
// flit_depacketizer_if: flit input channel and reassembled message output channel
interface flit_depacketizer_if #(
    parameter int FLIT_WIDTH      = 261,
    parameter int FLIT_DATA_WIDTH = 256,
    parameter int MAX_FLITS       = 4
);
    logic [FLIT_WIDTH-1:0]                get_flit;
    logic                                 get_flit_valid;
    logic                                 get_flit_ready;
    logic [MAX_FLITS*FLIT_DATA_WIDTH-1:0] msg_data;
    logic [$clog2(MAX_FLITS):0]           msg_len;
    logic                                 msg_err;
    logic                                 msg_valid;
    logic                                 msg_ready;

    modport master (
        output get_flit, get_flit_valid, msg_ready,
        input  get_flit_ready, msg_data, msg_len, msg_err, msg_valid
    );

    modport slave (
        input  get_flit, get_flit_valid, msg_ready,
        output get_flit_ready, msg_data, msg_len, msg_err, msg_valid
    );
endinterface

// File: rtl/flit_depacketizer.sv
// flit_depacketizer: gathers flits into a message buffer and hands it out as one wide message
module flit_depacketizer #(
    parameter int FLIT_WIDTH      = 261,
    parameter int FLIT_DATA_WIDTH = 256,
    parameter int MAX_FLITS       = 4
) (
    input logic               CLK,
    input logic               RST,
    flit_depacketizer_if.slave bus
);
    localparam int IDX_W = $clog2(MAX_FLITS);
    localparam int LEN_W = $clog2(MAX_FLITS) + 1;

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                                   state, state_n;
    logic [IDX_W-1:0]                         idx, idx_n;
    logic [MAX_FLITS-1:0][FLIT_DATA_WIDTH-1:0] slots, slots_n;
    logic [LEN_W-1:0]                         len, len_n;
    logic                                     err, err_n;
    logic                                     tail, flit_fire, msg_fire;
    logic [FLIT_DATA_WIDTH-1:0]               payload;
    logic                                     unused_bits;

    assign tail               = bus.get_flit[FLIT_WIDTH-2];
    assign payload            = bus.get_flit[FLIT_DATA_WIDTH-1:0];
    assign unused_bits        = ^{bus.get_flit[FLIT_WIDTH-1], bus.get_flit[FLIT_WIDTH-3:FLIT_DATA_WIDTH]};
    assign bus.get_flit_ready = !RST && (state == COLLECT || bus.msg_ready);
    assign bus.msg_valid      = !RST && state == HOLD;
    assign flit_fire          = bus.get_flit_valid && bus.get_flit_ready;
    assign msg_fire           = bus.msg_valid && bus.msg_ready;
    assign bus.msg_data       = slots;
    assign bus.msg_len        = len;
    assign bus.msg_err        = err;

    // state and message buffer registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= COLLECT;
            idx   <= '0;
            slots <= '0;
            len   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            slots <= slots_n;
            len   <= len_n;
            err   <= err_n;
        end
    end

    // next state: collect flits until tail or full, hold until drained (refill in the same cycle)
    always_comb begin
        state_n = state;
        idx_n   = idx;
        slots_n = slots;
        len_n   = len;
        err_n   = err;
        if (state == COLLECT) begin
            if (flit_fire) begin
                slots_n[idx] = payload;
                if (tail || idx == IDX_W'(MAX_FLITS - 1)) begin
                    state_n = HOLD;
                    len_n   = LEN_W'(idx) + 1'b1;
                    err_n   = !tail;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + 1'b1;
                end
            end
        end else if (msg_fire) begin
            state_n = COLLECT;
            slots_n = '0;
            idx_n   = '0;
            if (flit_fire) begin
                slots_n[0] = payload;
                if (tail) begin
                    state_n = HOLD;
                    len_n   = LEN_W'(1);
                    err_n   = 1'b0;
                end else begin
                    idx_n = IDX_W'(1);
                end
            end
        end
    end
endmodule
